// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Row-drive encoding, FSM states and key-code width.
package keypad_pkg;

  localparam int KEY_W = 4;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_e;

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    row_drive = ROW_IDLE & ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scan_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
// Reset value is a parameter so idle lines come up inactive.
module sync_2ff #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two back-to-back stages to let metastability resolve
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with press/release debounce.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key is held.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SETTLE       = 3,
  parameter int DEBOUNCE_CYC = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic             clk,
  input  logic             rst,
  output logic [3:0]       key_row,
  input  logic [3:0]       key_col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam int TOP_A = (DEBOUNCE_CYC > REPEAT_DELAY) ?
                         DEBOUNCE_CYC : REPEAT_DELAY;
  localparam int TOP_B = (TOP_A > REPEAT_RATE) ? TOP_A : REPEAT_RATE;
  localparam int TOP_C = (TOP_B > SETTLE) ? TOP_B : SETTLE;
  localparam int CNT_W = $clog2(TOP_C + 1);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] SET_C   = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEBOUNCE_CYC);

  logic [3:0]       col_s;
  logic             col_bit;
  logic [1:0]       low_col;
  logic [CNT_W-1:0] cnt_inc;
  logic             rep_fire;

  state_e           state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_row_q, key_row_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;

  sync_2ff #(
    .W      (4),
    .RST_VAL(ROW_IDLE)
  ) u_col_sync (
    .clk(clk),
    .rst(rst),
    .d  (key_col),
    .q  (col_s)
  );

  assign col_bit = col_s[col_q];
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  // Lowest-index low column wins when several are pressed
  always_comb begin
    low_col = 2'd3;
    if (!col_s[0])      low_col = 2'd0;
    else if (!col_s[1]) low_col = 2'd1;
    else if (!col_s[2]) low_col = 2'd2;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_C = CNT_W'(REPEAT_RATE);

  logic [CNT_W-1:0] rep_q, rep_d, rep_inc;
  logic             first_q, first_d;

  // Repeat timer runs in PRESSED, freezes in RELEASE, clears otherwise
  always_comb begin
    rep_d    = rep_q;
    first_d  = first_q;
    rep_fire = 1'b0;
    rep_inc  = (rep_q == CNT_SAT) ? rep_q : rep_q + CNT_W'(1);
    unique case (state_q)
      SCAN, DEBOUNCE: begin
        rep_d   = '0;
        first_d = 1'b1;
      end
      PRESSED: begin
        if (!col_bit) begin
          rep_d = rep_inc;
          if (rep_inc == (first_q ? DLY_C : RATE_C)) begin
            rep_fire = 1'b1;
            rep_d    = '0;
            first_d  = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // Repeat timer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q   <= '0;
      first_q <= 1'b1;
    end else begin
      rep_q   <= rep_d;
      first_q <= first_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Scan / debounce / hold / release sequencing
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    unique case (state_q)
      SCAN: begin
        if (cnt_q >= SET_C) begin
          cnt_d = '0;
          if (!(&col_s)) begin
            col_d   = low_col;
            state_d = DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DEBOUNCE: begin
        if (!col_bit) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB_C) begin
            state_d = PRESSED;
            code_d  = {row_q, col_q};
            valid_d = 1'b1;
            held_d  = 1'b1;
            cnt_d   = '0;
          end
        end else begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (col_bit) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
          valid_d = rep_fire;
        end
      end
      RELEASE: begin
        if (col_bit) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB_C) begin
            held_d  = 1'b0;
            state_d = SCAN;
            row_d   = row_q + 2'd1;
            cnt_d   = '0;
          end
        end else begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      default: state_d = SCAN;
    endcase
    key_row_d = row_drive(row_d);
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      row_q     <= '0;
      col_q     <= '0;
      cnt_q     <= '0;
      key_row_q <= row_drive(2'd0);
      code_q    <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      key_row_q <= key_row_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign key_row   = key_row_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan with a matrix keypad model.
// Expected pulses (code + cycle window) queued at stimulus time.
module tb_keypad_scan;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_DLY  = 100;
  localparam int REP_RATE = 30;
`else
  localparam int REP_DLY  = 500;
  localparam int REP_RATE = 100;
`endif
  localparam int LAT = 3 + 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pr = '0;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int code;
    int lo;
    int hi;
  } exp_t;

  exp_t sb[$];

  keypad_scan #(
    .SETTLE      (3),
    .DEBOUNCE_CYC(20),
    .REPEAT_DELAY(REP_DLY),
    .REPEAT_RATE (REP_RATE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!key_row[r]) key_col = key_col & ~pr[r*4 +: 4];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (key_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("valid_code", key_code, e.code);
        if (e.lo == e.hi)
          check("valid_cycle", cyc, e.lo);
        else
          check("valid_window", (cyc >= e.lo && cyc <= e.hi), 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic press_on_row(input int r, input logic [3:0] cols,
                              output int e0);
    int k;
    k = 0;
    while (key_row[r] !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    pr[r*4 +: 4] = cols;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (key_row[r] !== 1'b0 && k < 100);
    check("row_reached", (k < 100), 1);
    e0 = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish after %0d cycles", cyc);
    $fatal(1);
  end

  initial begin
    int e0, rel, t, k;
    rst = 1'b1;
    tick(3);
    check("rst_row", key_row, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_code", key_code, 0);
    rst = 1'b0;

    // r2c1 held 60 cycles
    press_on_row(2, 4'b0010, e0);
    sb.push_back('{9, e0 + LAT, e0 + LAT});
    wait_cyc(e0 + LAT - 1);
    check("a_held_pre", key_held, 0);
    wait_cyc(e0 + 30);
    check("a_held", key_held, 1);
    check("a_row_frozen", key_row, 4'b1011);
    wait_cyc(e0 + 60);
    pr = '0;
    rel = cyc;
    wait_cyc(rel + 22);
    check("a_held_late", key_held, 1);
    wait_cyc(rel + 23);
    check("a_held_drop", key_held, 0);
    check("a_row_next", key_row, 4'b0111);

    // reset in the middle of debouncing r1c1
    press_on_row(1, 4'b0010, e0);
    wait_cyc(e0 + 10);
    rst = 1'b1;
    tick(1);
    check("b_row", key_row, 4'b1110);
    check("b_valid", key_valid, 0);
    check("b_held", key_held, 0);
    check("b_code", key_code, 0);
    pr = '0;
    tick(2);
    rst = 1'b0;
    t = cyc;
    wait_cyc(t + 2);
    check("b_row0_hold", key_row, 4'b1110);
    wait_cyc(t + 3);
    check("b_row1", key_row, 4'b1101);

    // r0c3 bouncing, then stable
    for (int i = 0; i < 5; i++) begin
      pr[3] = 1'b1;
      tick(5);
      pr[3] = 1'b0;
      tick(3);
    end
    pr[3] = 1'b1;
    t = cyc;
    sb.push_back('{3, t + 23, t + 34});
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      tick(1);
      k++;
    end
    check("c_pulse_seen", sb.size(), 0);
    sb.delete();
    pr = '0;
    tick(30);

    // r1c0 + r1c2 together, then drop c0 only
    press_on_row(1, 4'b0101, e0);
    sb.push_back('{4, e0 + LAT, e0 + LAT});
    wait_cyc(e0 + 30);
    pr[4] = 1'b0;
    rel = cyc;
    sb.push_back('{6, rel + 55, rel + 55});
    wait_cyc(rel + 23);
    check("d_held_drop", key_held, 0);
    check("d_row_next", key_row, 4'b1011);
    wait_cyc(rel + 56);
    check("d_held_again", key_held, 1);
    pr = '0;
    tick(30);

    // r3c2 with a short re-press glitch during release
    press_on_row(3, 4'b0100, e0);
    sb.push_back('{14, e0 + LAT, e0 + LAT});
    wait_cyc(e0 + 30);
    pr = '0;
    rel = cyc;
    wait_cyc(rel + 10);
    pr[14] = 1'b1;
    wait_cyc(rel + 12);
    pr[14] = 1'b0;
    wait_cyc(rel + 23);
    check("e_held_glitch", key_held, 1);
    wait_cyc(rel + 34);
    check("e_held_late", key_held, 1);
    wait_cyc(rel + 35);
    check("e_held_drop", key_held, 0);
    check("e_code_kept", key_code, 14);

`ifdef KEYPAD_REPEAT_EN
    // r0c0 held well past the repeat delay
    tick(10);
    press_on_row(0, 4'b0001, e0);
    t = e0 + LAT;
    sb.push_back('{0, t, t});
    sb.push_back('{0, t + 100, t + 100});
    sb.push_back('{0, t + 130, t + 130});
    sb.push_back('{0, t + 160, t + 160});
    sb.push_back('{0, t + 190, t + 190});
    wait_cyc(t + 200);
    pr = '0;
    tick(30);
`endif

    tick(5);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
